// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, register-file constants, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Default maximum number of memory-wait cycles before the access is abandoned.
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: count reflects an increment on the edge after inc is sampled.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
// Ports: clk, clr (sync clear), inc (count enable), cnt (W-bit count).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait holds with timeout, branch/jump flushes.
// Latency: hold/bubble/flush outputs are combinational in the same cycle; bus_err and stall_cnt are registered.
// Backpressure: a pending memory access holds the whole pipeline until ack or timeout; load-use stalls one cycle.
// Ports: EX-stage Rs/Rt and use flags, MEM-stage load/dest, mem_req/mem_ack handshake, EX branch/jump
//        resolution in; datahazard, exmem_bubble, memhold, ifid_flush, idex_flush, bus_err, stall_cnt out.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_uses_rs,
    input  logic             ex_uses_rt,
    input  logic             mem_memrd,
    input  logic [4:0]       mem_rd,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    output logic             datahazard,
    output logic             exmem_bubble,
    output logic             memhold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] to_cnt, to_cnt_nxt;
    logic        bus_err_nxt;
    logic        lu;
    logic        mw;

    // Load in MEM feeds a register the EX instruction reads; forwarding cannot cover it yet.
    assign lu = mem_memrd && (mem_rd != ZERO_REG) &&
                ((ex_uses_rs && (ex_rs == mem_rd)) || (ex_uses_rt && (ex_rt == mem_rd)));

    // An ack without a request is meaningless and is masked here.
    assign mw = mem_req && !mem_ack;

    always_comb begin
        datahazard   = 1'b0;
        exmem_bubble = 1'b0;
        memhold      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        state_nxt    = state;
        to_cnt_nxt   = to_cnt;
        bus_err_nxt  = 1'b0;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (mw) begin
                        datahazard = 1'b1;
                        memhold    = 1'b1;
                        state_nxt  = MEMWAIT;
                        to_cnt_nxt = 16'd1;
                    end else if (lu) begin
                        // A branch resolved this cycle used stale operands; it re-resolves
                        // next cycle once the load data is forwardable, so no flush here.
                        datahazard   = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (ex_branch_taken || ex_jump) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    datahazard = 1'b1;
                    memhold    = 1'b1;
                    if (mem_ack) begin
                        state_nxt = IDLE;
                    end else if (to_cnt == TIMEOUT_V) begin
                        state_nxt   = IDLE;
                        bus_err_nxt = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 16'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            to_cnt  <= 16'd0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            to_cnt  <= to_cnt_nxt;
            bus_err <= bus_err_nxt;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .clr(reset),
        .inc(datahazard),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter (saturates at 15).
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ex_rs, ex_rt, mem_rd;
    logic       ex_uses_rs, ex_uses_rt, mem_memrd, mem_req, mem_ack;
    logic       ex_branch_taken, ex_jump;
    logic       datahazard, exmem_bubble, memhold, ifid_flush, idex_flush, bus_err;
    logic [3:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Output bundle order: {datahazard, exmem_bubble, memhold, ifid_flush, idex_flush}
    logic [4:0] outs;
    assign outs = {datahazard, exmem_bubble, memhold, ifid_flush, idex_flush};

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_LU    = 5'b11000;
    localparam logic [4:0] O_HOLD  = 5'b10100;
    localparam logic [4:0] O_FLUSH = 5'b00011;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_uses_rs(ex_uses_rs), .ex_uses_rt(ex_uses_rt),
        .mem_memrd(mem_memrd), .mem_rd(mem_rd), .mem_req(mem_req), .mem_ack(mem_ack),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .datahazard(datahazard), .exmem_bubble(exmem_bubble), .memhold(memhold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_rs = 5'd0; ex_rt = 5'd0; ex_uses_rs = 1'b0; ex_uses_rt = 1'b0;
        mem_memrd = 1'b0; mem_rd = 5'd0; mem_req = 1'b0; mem_ack = 1'b0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0;
    endtask

    task automatic set_lu_rt8();
        mem_memrd = 1'b1; mem_rd = 5'd8; ex_rt = 5'd8; ex_uses_rt = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_lu_rt8();
        mem_req = 1'b1;
        ex_jump = 1'b1;
        tick(); tick();
        vectors++;
        if (outs !== O_NONE) begin
            $display("FAIL reset_comb: outs=%b want=%b", outs, O_NONE); miscompares++;
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        vectors++;
        if (stall_cnt !== 4'd0 || bus_err !== 1'b0 || outs !== O_NONE) begin
            $display("FAIL reset_state: cnt=%0d bus_err=%b outs=%b want 0/0/%b",
                     stall_cnt, bus_err, outs, O_NONE); miscompares++;
        end
    endtask

    task automatic test_load_use();
        // Rs matches but is not read: no stall
        mem_memrd = 1'b1; mem_rd = 5'd8; ex_rs = 5'd8; ex_uses_rs = 1'b0;
        #1;
        vectors++;
        if (outs !== O_NONE) begin
            $display("FAIL lu_rs_unused: outs=%b want=%b", outs, O_NONE); miscompares++;
        end
        set_lu_rt8();
        #1;
        vectors++;
        if (outs !== O_LU) begin
            $display("FAIL lu_rt: outs=%b want=%b", outs, O_LU); miscompares++;
        end
        tick();
        idle_inputs();  // bubble now sits in MEM
        #1;
        vectors++;
        if (outs !== O_NONE || stall_cnt !== 4'd1) begin
            $display("FAIL lu_after: outs=%b cnt=%0d want %b/1", outs, stall_cnt, O_NONE); miscompares++;
        end
    endtask

    task automatic test_zero_reg();
        mem_memrd = 1'b1; mem_rd = 5'd0; ex_rs = 5'd0; ex_uses_rs = 1'b1;
        ex_rt = 5'd0; ex_uses_rt = 1'b1;
        #1;
        vectors++;
        if (outs !== O_NONE) begin
            $display("FAIL zero_reg: outs=%b want=%b", outs, O_NONE); miscompares++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_ack_without_req();
        mem_ack = 1'b1;
        #1;
        vectors++;
        if (outs !== O_NONE) begin
            $display("FAIL ack_no_req: outs=%b want=%b", outs, O_NONE); miscompares++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_memwait();
        mem_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            mem_ack = (c == 3);
            #1;
            vectors++;
            if (outs !== O_HOLD) begin
                $display("FAIL memwait_c%0d: outs=%b want=%b", c, outs, O_HOLD); miscompares++;
            end
            tick();
        end
        idle_inputs();
        #1;
        vectors++;
        if (outs !== O_NONE || stall_cnt !== 4'd4 || bus_err !== 1'b0) begin
            $display("FAIL memwait_done: outs=%b cnt=%0d bus_err=%b want %b/4/0",
                     outs, stall_cnt, bus_err, O_NONE); miscompares++;
        end
    endtask

    task automatic test_timeout();
        mem_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            vectors++;
            if (outs !== O_HOLD || bus_err !== 1'b0) begin
                $display("FAIL timeout_c%0d: outs=%b bus_err=%b want %b/0", c, outs, bus_err, O_HOLD);
                miscompares++;
            end
            tick();
        end
        // Back in IDLE: a load-use pattern must give a load-use stall, not a hold
        mem_req = 1'b0;
        set_lu_rt8();
        #1;
        vectors++;
        if (bus_err !== 1'b1 || outs !== O_LU || stall_cnt !== 4'd9) begin
            $display("FAIL timeout_end: bus_err=%b outs=%b cnt=%0d want 1/%b/9",
                     bus_err, outs, stall_cnt, O_LU); miscompares++;
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus_err !== 1'b0 || stall_cnt !== 4'd10) begin
            $display("FAIL timeout_pulse: bus_err=%b cnt=%0d want 0/10", bus_err, stall_cnt);
            miscompares++;
        end
    endtask

    task automatic test_priority();
        mem_req = 1'b1;
        set_lu_rt8();
        ex_jump = 1'b1;
        #1;
        vectors++;
        if (outs !== O_HOLD) begin
            $display("FAIL prio_idle: outs=%b want=%b", outs, O_HOLD); miscompares++;
        end
        tick();
        mem_ack = 1'b1;
        #1;
        vectors++;
        if (outs !== O_HOLD) begin
            $display("FAIL prio_memwait: outs=%b want=%b", outs, O_HOLD); miscompares++;
        end
        tick();
        idle_inputs();
        ex_jump = 1'b1;
        #1;
        vectors++;
        if (outs !== O_FLUSH || stall_cnt !== 4'd12) begin
            $display("FAIL prio_jump: outs=%b cnt=%0d want %b/12", outs, stall_cnt, O_FLUSH);
            miscompares++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_during_lu();
        set_lu_rt8();
        ex_branch_taken = 1'b1;
        #1;
        vectors++;
        if (outs !== O_LU) begin
            $display("FAIL br_lu: outs=%b want=%b", outs, O_LU); miscompares++;
        end
        tick();
        mem_memrd = 1'b0;
        #1;
        vectors++;
        if (outs !== O_FLUSH) begin
            $display("FAIL br_resolve: outs=%b want=%b", outs, O_FLUSH); miscompares++;
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (outs !== O_NONE || stall_cnt !== 4'd13) begin
            $display("FAIL br_after: outs=%b cnt=%0d want %b/13", outs, stall_cnt, O_NONE);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        set_lu_rt8();
        for (int c = 0; c < 5; c++) tick();
        idle_inputs();
        #1;
        vectors++;
        if (stall_cnt !== 4'd15) begin
            $display("FAIL saturate: cnt=%0d want 15", stall_cnt); miscompares++;
        end
    endtask

    task automatic test_reset_memwait();
        logic seen_err;
        seen_err = 1'b0;
        mem_req = 1'b1;
        tick();          // now in MEMWAIT, 2nd wait cycle
        reset = 1'b1;
        #1;
        vectors++;
        if (outs !== O_NONE) begin
            $display("FAIL rst_mw_comb: outs=%b want=%b", outs, O_NONE); miscompares++;
        end
        tick();
        reset = 1'b0;
        mem_req = 1'b0;
        set_lu_rt8();    // IDLE must answer with a load-use stall, not a hold
        #1;
        vectors++;
        if (outs !== O_LU || stall_cnt !== 4'd0 || bus_err !== 1'b0) begin
            $display("FAIL rst_mw_after: outs=%b cnt=%0d bus_err=%b want %b/0/0",
                     outs, stall_cnt, bus_err, O_LU); miscompares++;
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_err !== 1'b0) seen_err = 1'b1;
        end
        vectors++;
        if (seen_err !== 1'b0) begin
            $display("FAIL rst_mw_no_err: bus_err seen=%b want 0", seen_err); miscompares++;
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_ack_without_req();
        test_memwait();
        test_timeout();
        test_priority();
        test_branch_during_lu();
        test_saturation();
        test_reset_memwait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller: drives the `datahazard` hold input of the ID/EX register and the matching holds, bubbles and flushes for the other pipeline registers. It consumes EX-stage register fields from the ID/EX outputs, MEM-stage load information, the data-memory handshake and EX-stage branch/jump resolution. It handles three cases:
- load-use stalls;
- multi-cycle data-memory waits, with a timeout;
- control-transfer flushes.

It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- TIMEOUT, 255: maximum MEMWAIT cycles before `bus_err` is raised. Range 1..65535.
- CNT_W, 16: width of `stall_cnt`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- ex_rs  in  5  Rs of the instruction in EX (ID/EX `Rsout`).
- ex_rt  in  5  Rt of the instruction in EX (ID/EX `Rtout`).
- ex_uses_rs  in  1  EX instruction reads Rs.
- ex_uses_rt  in  1  EX instruction reads Rt.
- mem_memrd  in  1  instruction in MEM is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ack  in  1  data memory completes the access this cycle.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_jump  in  1  register jump (jr/jalr) in EX.
- datahazard  out  1  hold PC, IF/ID and ID/EX.
- exmem_bubble  out  1  write zero control fields into EX/MEM.
- memhold  out  1  hold EX/MEM and MEM/WB.
- ifid_flush  out  1  clear IF/ID to a nop.
- idex_flush  out  1  clear ID/EX controls to a nop.
- bus_err  out  1  one-cycle pulse when a memory wait times out.
- stall_cnt  out  CNT_W  saturating count of cycles with datahazard=1.

## Operation
- FSM states: IDLE, MEMWAIT. State, timeout counter, `stall_cnt` and `bus_err` are registered. All other outputs are combinational from state and inputs.
- `lu` = mem_memrd & (mem_rd != 0) & ((ex_uses_rs & ex_rs == mem_rd) | (ex_uses_rt & ex_rt == mem_rd)).
- `mw` = mem_req & ~mem_ack.
- IDLE, `mw`=1:
  - Outputs: datahazard=1, memhold=1, exmem_bubble=0. No flush.
  - Next state MEMWAIT; timeout counter loads 1.
- IDLE, `mw`=0, `lu`=1:
  - Outputs: datahazard=1, exmem_bubble=1, memhold=0.
  - No flush, even if ex_branch_taken or ex_jump is asserted. The branch operands are stale; the branch re-resolves next cycle.
- IDLE, `mw`=0, `lu`=0, and (ex_branch_taken | ex_jump):
  - Outputs: ifid_flush=1, idex_flush=1.
- MEMWAIT:
  - Outputs: datahazard=1, memhold=1.
  - All other comb outputs are 0; `lu` and flush inputs are ignored.
  - mem_ack=1 → IDLE (this last held cycle still has outputs as above).
  - Otherwise, if the counter equals TIMEOUT → IDLE, with bus_err=1 in the following cycle.
  - Otherwise the counter increments.
- `stall_cnt` increments on every cycle with datahazard=1. It saturates at 2^CNT_W−1.
- mem_ack without mem_req is ignored.

## Timing
- Reset: state=IDLE, timeout counter=0, stall_cnt=0, bus_err=0.
- While reset=1, all combinational outputs are forced to 0.
- Load-use costs exactly 1 stall cycle. The next cycle, MEM holds the bubble, so `lu`=0 with no extra state needed.
- Memory wait with ack on the k-th cycle after the request: datahazard=1 for k cycles, then the pipeline advances.
- Memory wait that times out: datahazard=1 for TIMEOUT+1 cycles, and bus_err pulses on the cycle after the last held cycle.
- A flush lasts one cycle and is never combined with datahazard.
- Priority is memhold > load-use > flush.
- Reset asserted in MEMWAIT returns to IDLE on the next edge; no bus_err is raised.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding (IDLE=1'b0, MEMWAIT=1'b1);
  - register-index constant ZERO_REG=5'd0;
  - the TIMEOUT default.
- One sub-module is natural: `sat_counter` (CNT_W-bit saturating up-counter with synchronous clear). It is instantiated for `stall_cnt`.

## Test plan
- Load-use on Rt: mem_memrd=1, mem_rd=8, ex_rt=8, ex_uses_rt=1 → datahazard=1 and exmem_bubble=1 for exactly one cycle; stall_cnt=1.
- Zero destination: mem_memrd=1, mem_rd=0, ex_rs=0, ex_uses_rs=1 → no stall.
- Memory wait: mem_req=1 with ack on the 3rd cycle → datahazard=memhold=1 for 3 cycles, then 0; stall_cnt=3.
- Timeout with TIMEOUT=4 and mem_req=1 with no ack → 5 held cycles, then bus_err=1 for 1 cycle, then state IDLE.
- Branch taken during load-use: lu=1 and ex_branch_taken=1 → no flush in that cycle. Next cycle (lu=0, taken=1) → ifid_flush=idex_flush=1 for 1 cycle.
- Reset mid-MEMWAIT in the 2nd wait cycle → all outputs 0 and stall_cnt=0 after the edge; bus_err is never raised.
